mem_arbiter: RTL and testbench

Round-robin arbiter that shares one native-protocol memory/IO port (valid/ready, 32-bit addr/wdata, 4-bit wstrb, 32-bit rdata) between NUM_REQ PicoRV32 cores. It sits between the cores and the existing single-port memory/IO decode logic (BRAM at 0x0xxxxxxx, LEDs at 0x1xxxxxxx, UART at 0x2xxxxxxx). It is the enabling block for the multicore top. It serialises transactions, holds at most one outstanding request, and returns read data and ready only to the granted core.

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/rr_picker.sv | 49 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the multicore native memory bus:
// arbiter FSM states, top-level address regions and default bus widths.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Top nibble of the address selects the target behind the shared port.
    localparam logic [3:0] REGION_MEM  = 4'h0;
    localparam logic [3:0] REGION_LED  = 4'h1;
    localparam logic [3:0] REGION_UART = 4'h2;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

    // True when the address falls in one of the decoded regions.
    function automatic logic is_known_region(input logic [31:0] addr);
        return (addr[31:28] == REGION_MEM) || (addr[31:28] == REGION_LED) ||
               (addr[31:28] == REGION_UART);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the per-core request bus and the shared memory/IO port.
// The slave modport is the arbiter's view; master is the cores + memory side.
interface mem_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = $clog2(NUM_REQ);

    // Core side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_wstrb;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         req_rdata;

    // Shared port side
    logic                      mem_valid;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [STRB_W-1:0]         mem_wstrb;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_rdata;

    logic [ID_W-1:0]           grant_id;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output grant_id
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  grant_id
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational one-hot winner select over a request vector.
// With MEM_ARBITER_ROUND_ROBIN_EN the search starts just above ptr and
// wraps; without it this is a plain lowest-index priority encoder.
module rr_picker
    import mem_bus_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]    gnt_id
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Scan distances from farthest to nearest so the nearest requester above ptr wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_oh = '0;
        gnt_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    gnt_oh    = '0;
                    gnt_oh[i] = 1'b1;
                    gnt_id    = ID_W'(i);
                end
            end
        end
    end
`else
    // Scan from the top down so the lowest requesting index wins.
    always_comb begin
        gnt_oh = '0;
        gnt_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one native valid/ready memory/IO port between NUM_REQ
// cores. One transaction in flight; IDLE -> BUSY -> RESP -> IDLE.
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest requesting core always wins.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic          clk,
    input logic          resetn,
    mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [STRB_W-1:0]  win_wstrb;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (bus.req_valid),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        .ptr    (ptr),
`endif
        .gnt_oh (win_oh),
        .gnt_id (win_id)
    );

    // Route the winning core's request fields toward the mem_* registers.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                win_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Transaction FSM; every bus output is a register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            grant_oh      <= '0;
            bus.grant_id  <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.req_ready <= '0;
            bus.req_rdata <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr           <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            // NOTE: non-blocking assignments; this default is overridden later in the same cycle.
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant_oh      <= win_oh;
                        bus.grant_id  <= win_id;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_wstrb <= win_wstrb;
                        bus.mem_valid <= 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        ptr           <= win_id;
`endif
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.req_rdata <= bus.mem_rdata;
                        bus.mem_valid <= 1'b0;
                        bus.req_ready <= grant_oh;
                        state         <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed tests push expected shared-port
// requests and core responses into queues; a memory model and a response
// monitor pop and compare whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int          core;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t core_q [NUM_REQ][$];
    txn_t exp_mem_q [$];
    txn_t exp_rsp_q [$];

    int n_pass    = 0;
    int n_total   = 0;
    int mem_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic issue(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        txn_t t;
        t.core = core; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rdata = '0;
        core_q[core].push_back(t);
    endtask

    // Expected grant in order; memory returns rdata; with_rsp adds the core response.
    task automatic expect_txn(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata, input bit with_rsp);
        txn_t t;
        t.core = core; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rdata = rdata;
        exp_mem_q.push_back(t);
        if (with_rsp) exp_rsp_q.push_back(t);
    endtask

    // Core models: present queued requests, hold valid until req_ready.
    always @(negedge clk) begin
        if (!resetn) begin
            bus.req_valid = '0;
            bus.req_addr  = '0;
            bus.req_wdata = '0;
            bus.req_wstrb = '0;
            for (int i = 0; i < NUM_REQ; i++) core_q[i].delete();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    void'(core_q[i].pop_front());
                    bus.req_valid[i] = 1'b0;
                end
                if (!bus.req_valid[i] && core_q[i].size() > 0) begin
                    bus.req_addr[i*ADDR_W +: ADDR_W]  = core_q[i][0].addr;
                    bus.req_wdata[i*DATA_W +: DATA_W] = core_q[i][0].wdata;
                    bus.req_wstrb[i*STRB_W +: STRB_W] = core_q[i][0].wstrb;
                    bus.req_valid[i] = 1'b1;
                end
            end
        end
    end

    // Memory model: check each new request against the scoreboard, check the
    // request stays stable, answer after mem_delay extra cycles.
    txn_t cur;
    int   cnt;
    bit   mbusy;
    always @(negedge clk) begin
        if (!resetn) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            mbusy         = 1'b0;
        end else if (mbusy) begin
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                mbusy         = 1'b0;
            end else begin
                check("mem_valid held", 32'(bus.mem_valid), 32'd1);
                check("mem_addr stable", bus.mem_addr, cur.addr);
                check("mem_wdata stable", bus.mem_wdata, cur.wdata);
                check("mem_wstrb stable", 32'(bus.mem_wstrb), 32'(cur.wstrb));
                if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = cur.rdata;
                end
            end
        end else if (bus.mem_valid) begin
            if (exp_mem_q.size() == 0) begin
                check("mem request with none expected", 32'(bus.mem_valid), 32'd0);
                cur.core = 0; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
                cur.wstrb = bus.mem_wstrb; cur.rdata = '0;
            end else begin
                cur = exp_mem_q.pop_front();
                check("grant_id", 32'(bus.grant_id), 32'(cur.core));
                check("mem_addr", bus.mem_addr, cur.addr);
                check("mem_wdata", bus.mem_wdata, cur.wdata);
                check("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.wstrb));
            end
            mbusy = 1'b1;
            cnt   = mem_delay;
            if (cnt == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = cur.rdata;
            end
        end
    end

    // Response monitor: every req_ready pulse must match the next expected response.
    always @(negedge clk) begin
        if (resetn && bus.req_ready != '0) begin
            if (exp_rsp_q.size() == 0) begin
                check("req_ready with none expected", 32'(bus.req_ready), 32'd0);
            end else begin
                txn_t e;
                e = exp_rsp_q.pop_front();
                check("req_ready lane", 32'(bus.req_ready), 32'd1 << e.core);
                check("req_rdata", bus.req_rdata, e.rdata);
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        while ((exp_rsp_q.size() > 0 || exp_mem_q.size() > 0 || core_q[0].size() > 0 ||
                core_q[1].size() > 0 || bus.req_valid != '0 || bus.mem_valid) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " completes in budget"}, 32'(cyc < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        exp_mem_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst req_rdata", bus.req_rdata, 32'd0);
        check("rst grant_id", 32'(bus.grant_id), 32'd0);
        #2 resetn = 1'b1;
        @(negedge clk);

        // Single read by core 0
        mem_delay = 0;
        expect_txn(0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        issue(0, 32'h0000_0010, 32'h0, 4'h0);
        wait_done("single read", 20);

        // Simultaneous requests right after reset: core 0 then core 1
        apply_reset();
        expect_txn(0, 32'h0000_0020, 32'h0, 4'h0, 32'h1111_0000, 1'b1);
        expect_txn(1, 32'h0000_0024, 32'h0, 4'h0, 32'h2222_0001, 1'b1);
        issue(1, 32'h0000_0024, 32'h0, 4'h0);
        issue(0, 32'h0000_0020, 32'h0, 4'h0);
        wait_done("simultaneous", 30);

        // Continuous contention: core 0 has 8 requests, core 1 has 4
        apply_reset();
        for (int j = 0; j < 8; j++) issue(0, 32'h0000_0100 + 32'(4*j), 32'h0, 4'h0);
        for (int j = 0; j < 4; j++) issue(1, 32'h0000_0200 + 32'(4*j), 32'h0, 4'h0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        for (int j = 0; j < 4; j++) begin
            expect_txn(0, 32'h0000_0100 + 32'(4*j), 32'h0, 4'h0, 32'hA000_0000 + 32'(j), 1'b1);
            expect_txn(1, 32'h0000_0200 + 32'(4*j), 32'h0, 4'h0, 32'hB000_0000 + 32'(j), 1'b1);
        end
        for (int j = 4; j < 8; j++)
            expect_txn(0, 32'h0000_0100 + 32'(4*j), 32'h0, 4'h0, 32'hA000_0000 + 32'(j), 1'b1);
`else
        for (int j = 0; j < 8; j++)
            expect_txn(0, 32'h0000_0100 + 32'(4*j), 32'h0, 4'h0, 32'hA000_0000 + 32'(j), 1'b1);
        for (int j = 0; j < 4; j++)
            expect_txn(1, 32'h0000_0200 + 32'(4*j), 32'h0, 4'h0, 32'hB000_0000 + 32'(j), 1'b1);
`endif
        wait_done("contention", 100);

        // Write pass-through with a slow shared port
        mem_delay = 5;
        expect_txn(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001, 32'h0, 1'b1);
        issue(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
        wait_done("write", 30);

        // Reset in the middle of a transaction owned by core 0
        mem_delay = 10;
        expect_txn(0, 32'h2000_0004, 32'h0, 4'h0, 32'h0, 1'b0);
        issue(0, 32'h2000_0004, 32'h0, 4'h0);
        begin
            int cyc = 0;
            while (!bus.mem_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("mid-reset request reached port", 32'(bus.mem_valid), 32'd1);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async reset mem_valid", 32'(bus.mem_valid), 32'd0);
        check("async reset req_ready", 32'(bus.req_ready), 32'd0);
        check("async reset mem_addr", bus.mem_addr, 32'd0);
        exp_mem_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        mem_delay = 0;
        expect_txn(0, 32'h0000_0040, 32'h0, 4'h0, 32'h5555_0000, 1'b1);
        expect_txn(1, 32'h2000_0008, 32'h0, 4'h0, 32'h6666_0001, 1'b1);
        issue(1, 32'h2000_0008, 32'h0, 4'h0);
        issue(0, 32'h0000_0040, 32'h0, 4'h0);
        wait_done("post-reset", 30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
